// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated register mux: arbitration modes and a clog2 helper.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } arb_mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: fixed priority (lowest index) or round-robin starting at ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int MODE   = 1,
  localparam int unsigned SEL_W = clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic              advance,
  output logic [NUM_IN-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] idx;
  logic             found;

  // Fixed priority is a round-robin search whose start pointer is pinned at 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = ptr_q;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
      idx = (idx == LAST) ? '0 : idx + SEL_W'(1);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == int'(MODE_RR) && advance) begin
      ptr_d = (grant_idx == LAST) ? '0 : grant_idx + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input arbitrated multiplexer with a one-entry registered output and valid/ready handshake.
module mux_arb_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int MODE   = 1,
  localparam int unsigned SEL_W = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              load, xfer;
  logic [WIDTH-1:0]  sel_data;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;
  logic              out_valid_q, out_valid_d;

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = grant & {NUM_IN{load & ~rst}};
  assign xfer     = |in_ready;

  rr_arbiter #(
    .NUM_IN(NUM_IN),
    .MODE  (MODE)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (in_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load) begin
      out_valid_d = |grant;
      if (|grant) begin
        out_data_d = sel_data;
        out_sel_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule
